// File: rtl/spi_device_fifo.sv
// SPI target with parametrised word width and CPOL/CPHA mode, oversampled on clk, fed by a TX FIFO.
// Defining SPI_DEVICE_FIFO_STATUS_EN adds sticky tx_underrun/frame_abort flags and a status_clear input.
module spi_device_fifo #(
    parameter int WIDTH    = 8,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0,
    parameter int TX_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        spi_sck,
    input  logic                        spi_cs_n,
    input  logic                        spi_sdi,
    output logic                        spi_sdo,
    output logic [WIDTH-1:0]            rx_data,
    output logic                        rx_strobe,
    input  logic [WIDTH-1:0]            tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level
`ifdef SPI_DEVICE_FIFO_STATUS_EN
    ,
    output logic                        tx_underrun,
    output logic                        frame_abort,
    input  logic                        status_clear
`endif
);

    localparam int AW    = $clog2(TX_DEPTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic SCK_IDLE = (CPOL != 0);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
    localparam logic [AW:0]      DEPTH_LVL = (AW + 1)'(TX_DEPTH);

    logic [1:0]       cs_sync;
    logic [2:0]       sck_sync;
    logic [2:0]       sdi_sync;
    logic             cs_prev;

    logic             armed;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;

    logic             cs_high;
    logic             cs_fall;
    logic             sck_changed;
    logic             lead_edge;
    logic             trail_edge;
    logic             word_done;
    logic             load;
    logic             sdi_bit;
    logic [WIDTH-1:0] rx_sampled;

    logic [WIDTH-1:0] mem [TX_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop_hit;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic [AW:0]      level_next;

    // CS syncs reset to "selected" so a device reset while CS is low stays disarmed until CS rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync  <= 2'b00;
            cs_prev  <= 1'b0;
            sck_sync <= {3{SCK_IDLE}};
            sdi_sync <= 3'b000;
        end else begin
            cs_sync  <= {cs_sync[0], spi_cs_n};
            cs_prev  <= cs_sync[1];
            sck_sync <= {sck_sync[1:0], spi_sck};
            sdi_sync <= {sdi_sync[1:0], spi_sdi};
        end
    end

    assign cs_high     = cs_sync[1];
    assign cs_fall     = armed && cs_prev && !cs_sync[1];
    assign sck_changed = armed && !cs_high && (sck_sync[1] != sck_sync[2]);
    assign lead_edge   = sck_changed && (sck_sync[1] != SCK_IDLE);
    assign trail_edge  = sck_changed && (sck_sync[1] == SCK_IDLE);
    assign sdi_bit     = sdi_sync[2];
    assign rx_sampled  = {rx_shift[WIDTH-2:0], sdi_bit};

    // Mode 0 finishes on the trailing edge after the last sample; mode 1 on the last sample itself.
    assign word_done = trail_edge && (bit_cnt == ((CPHA != 0) ? LAST_CNT : FULL_CNT));
    assign load      = cs_fall || word_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            armed     <= 1'b0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            rx_data   <= '0;
            rx_strobe <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            if (cs_high) begin
                armed    <= 1'b1;
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (load) begin
                tx_shift <= fifo_head;
                bit_cnt  <= '0;
                if (word_done) begin
                    rx_data   <= (CPHA != 0) ? rx_sampled : rx_shift;
                    rx_strobe <= 1'b1;
                end
            end else if (lead_edge) begin
                if (CPHA == 0) begin
                    rx_shift <= rx_sampled;
                    bit_cnt  <= bit_cnt + 1'b1;
                end else if (bit_cnt != '0) begin
                    tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                end
            end else if (trail_edge) begin
                if (CPHA == 0) begin
                    tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                end else begin
                    rx_shift <= rx_sampled;
                    bit_cnt  <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign spi_sdo = tx_shift[WIDTH-1];

    // A pop on an empty FIFO hands out zeros and leaves the pointers alone.
    assign fifo_empty = (tx_level == '0);
    assign push       = tx_valid && tx_ready;
    assign pop_hit    = load && !fifo_empty;
    assign fifo_head  = fifo_empty ? '0 : mem[rd_ptr];

    always_comb begin
        level_next = tx_level;
        if (push && !pop_hit) begin
            level_next = tx_level + 1'b1;
        end else if (!push && pop_hit) begin
            level_next = tx_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_level <= '0;
            tx_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_hit) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            tx_level <= level_next;
            tx_ready <= (level_next != DEPTH_LVL);
        end
    end

`ifdef SPI_DEVICE_FIFO_STATUS_EN
    logic abort_evt;

    assign abort_evt = !cs_prev && cs_sync[1] && (bit_cnt != '0);

    // A set event in the same cycle as status_clear takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            if (load && fifo_empty) begin
                tx_underrun <= 1'b1;
            end else if (status_clear) begin
                tx_underrun <= 1'b0;
            end
            if (abort_evt) begin
                frame_abort <= 1'b1;
            end else if (status_clear) begin
                frame_abort <= 1'b0;
            end
        end
    end
`else
    // Without the status option there is nothing extra to build.
`endif

endmodule

// File: tb/tb_spi_device_fifo.sv
// Directed bench for spi_device_fifo: a mode-0 8-bit instance and a mode-3 16-bit instance.
`timescale 1ns/1ps
module tb_spi_device_fifo;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        sck0, cs_n0, sdi0, sdo0;
    logic [7:0]  rx_data0, tx_data0;
    logic        rx_strobe0, tx_valid0, tx_ready0;
    logic [2:0]  tx_level0;

    logic        sck1, cs_n1, sdi1, sdo1;
    logic [15:0] rx_data1, tx_data1;
    logic        rx_strobe1, tx_valid1, tx_ready1;
    logic [2:0]  tx_level1;

`ifdef SPI_DEVICE_FIFO_STATUS_EN
    logic tx_underrun0, frame_abort0, status_clear0;
    logic tx_underrun1, frame_abort1, status_clear1;
`endif

    int vectors;
    int miscompares;
    int strb0;
    int strb1;
    logic [15:0] rx1_hist [8];

    spi_device_fifo #(.WIDTH(8), .CPOL(0), .CPHA(0), .TX_DEPTH(4)) dut0 (
        .clk(clk), .reset(reset),
        .spi_sck(sck0), .spi_cs_n(cs_n0), .spi_sdi(sdi0), .spi_sdo(sdo0),
        .rx_data(rx_data0), .rx_strobe(rx_strobe0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_level(tx_level0)
`ifdef SPI_DEVICE_FIFO_STATUS_EN
        , .tx_underrun(tx_underrun0), .frame_abort(frame_abort0), .status_clear(status_clear0)
`endif
    );

    spi_device_fifo #(.WIDTH(16), .CPOL(1), .CPHA(1), .TX_DEPTH(4)) dut1 (
        .clk(clk), .reset(reset),
        .spi_sck(sck1), .spi_cs_n(cs_n1), .spi_sdi(sdi1), .spi_sdo(sdo1),
        .rx_data(rx_data1), .rx_strobe(rx_strobe1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_level(tx_level1)
`ifdef SPI_DEVICE_FIFO_STATUS_EN
        , .tx_underrun(tx_underrun1), .frame_abort(frame_abort1), .status_clear(status_clear1)
`endif
    );

    // Strobes are counted on the falling edge, so a stretched strobe counts twice.
    always @(negedge clk) begin
        if (rx_strobe0) begin
            strb0++;
        end
        if (rx_strobe1) begin
            if (strb1 < 8) begin
                rx1_hist[strb1] = rx_data1;
            end
            strb1++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setSck(input int sel, input logic v);
        if (sel == 1) sck1 = v; else sck0 = v;
    endtask

    task automatic setCs(input int sel, input logic v);
        if (sel == 1) cs_n1 = v; else cs_n0 = v;
    endtask

    task automatic setSdi(input int sel, input logic v);
        if (sel == 1) sdi1 = v; else sdi0 = v;
    endtask

    function automatic logic sdoOf(input int sel);
        return (sel == 1) ? sdo1 : sdo0;
    endfunction

    task automatic pushWord(input int sel, input logic [15:0] data);
        @(negedge clk);
        if (sel == 1) begin
            tx_data1 = data; tx_valid1 = 1'b1;
        end else begin
            tx_data0 = data[7:0]; tx_valid0 = 1'b1;
        end
        @(negedge clk);
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
    endtask

    // One CS frame of nbits; instance 0 is driven in mode 0, instance 1 in mode 3. SCK half period = 8 clk.
    task automatic applyStimulus(input int sel, input int nbits, input logic [63:0] mosi, output logic [63:0] miso);
        logic idle;
        logic cpha;
        idle = (sel == 1);
        cpha = (sel == 1);
        miso = '0;
        @(negedge clk);
        setCs(sel, 1'b0);
        #80;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                setSdi(sel, mosi[i]);
                #80;
                miso = {miso[62:0], sdoOf(sel)};
                setSck(sel, !idle);
                #80;
                setSck(sel, idle);
            end else begin
                setSck(sel, !idle);
                setSdi(sel, mosi[i]);
                #80;
                miso = {miso[62:0], sdoOf(sel)};
                setSck(sel, idle);
                #80;
            end
        end
        #80;
        setCs(sel, 1'b1);
        #160;
    endtask

`ifdef SPI_DEVICE_FIFO_STATUS_EN
    task automatic pulseClear();
        @(negedge clk);
        status_clear0 = 1'b1;
        @(negedge clk);
        status_clear0 = 1'b0;
    endtask
`endif

    initial begin
        logic [63:0] miso;
        int base0;
        int base1;

        vectors = 0; miscompares = 0; strb0 = 0; strb1 = 0;
        reset = 1'b1;
        sck0 = 1'b0; cs_n0 = 1'b1; sdi0 = 1'b0; tx_data0 = '0; tx_valid0 = 1'b0;
        sck1 = 1'b1; cs_n1 = 1'b1; sdi1 = 1'b0; tx_data1 = '0; tx_valid1 = 1'b0;
`ifdef SPI_DEVICE_FIFO_STATUS_EN
        status_clear0 = 1'b0; status_clear1 = 1'b0;
`endif
        repeat (4) @(negedge clk);

        checkOutput("reset_rx_data", 64'(rx_data0), 64'h0);
        checkOutput("reset_rx_strobe", 64'(rx_strobe0), 64'h0);
        checkOutput("reset_sdo", 64'(sdo0), 64'h0);
        checkOutput("reset_tx_ready", 64'(tx_ready0), 64'h1);
        checkOutput("reset_tx_level", 64'(tx_level0), 64'h0);
        checkOutput("reset_rx_data_m3", 64'(rx_data1), 64'h0);
`ifdef SPI_DEVICE_FIFO_STATUS_EN
        checkOutput("reset_underrun", 64'(tx_underrun0), 64'h0);
        checkOutput("reset_abort", 64'(frame_abort0), 64'h0);
`endif
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0, 8 bits: device sends 0xA5 while receiving 0x3C.
        pushWord(0, 16'h00A5);
        checkOutput("m0_level_after_push", 64'(tx_level0), 64'h1);
        base0 = strb0;
        applyStimulus(0, 8, 64'h3C, miso);
        checkOutput("m0_miso", miso, 64'hA5);
        checkOutput("m0_rx_data", 64'(rx_data0), 64'h3C);
        checkOutput("m0_strobes", 64'(strb0 - base0), 64'h1);
        checkOutput("m0_level_after_frame", 64'(tx_level0), 64'h0);

        // Mode 3, 16 bits: two words in a single 32-bit frame.
        pushWord(1, 16'h1234);
        pushWord(1, 16'hBEEF);
        checkOutput("m3_level", 64'(tx_level1), 64'h2);
        base1 = strb1;
        applyStimulus(1, 32, 64'hCAFE5A5A, miso);
        checkOutput("m3_miso", miso, 64'h1234BEEF);
        checkOutput("m3_strobes", 64'(strb1 - base1), 64'h2);
        checkOutput("m3_rx_word0", 64'(rx1_hist[0]), 64'hCAFE);
        checkOutput("m3_rx_word1", 64'(rx1_hist[1]), 64'h5A5A);
        checkOutput("m3_level_after_frame", 64'(tx_level1), 64'h0);

        // Five back-to-back pushes into a 4-deep FIFO.
        @(negedge clk);
        tx_valid0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tx_data0 = 8'(8'h11 * (k + 1));
            @(negedge clk);
            if (k == 3) begin
                checkOutput("ovf_ready_after_4th", 64'(tx_ready0), 64'h0);
            end
        end
        tx_valid0 = 1'b0;
        checkOutput("ovf_level", 64'(tx_level0), 64'h4);
        checkOutput("ovf_ready", 64'(tx_ready0), 64'h0);
        base0 = strb0;
        applyStimulus(0, 40, 64'h0102030405, miso);
        checkOutput("ovf_miso_no_5th", miso, 64'h1122334400);
        checkOutput("ovf_strobes", 64'(strb0 - base0), 64'h5);
        checkOutput("ovf_last_rx", 64'(rx_data0), 64'h05);
        checkOutput("ovf_ready_after_drain", 64'(tx_ready0), 64'h1);

        // Empty FIFO transfer.
`ifdef SPI_DEVICE_FIFO_STATUS_EN
        pulseClear();
        checkOutput("udr_cleared", 64'(tx_underrun0), 64'h0);
`endif
        applyStimulus(0, 8, 64'h96, miso);
        checkOutput("udr_miso", miso, 64'h00);
        checkOutput("udr_rx_data", 64'(rx_data0), 64'h96);
`ifdef SPI_DEVICE_FIFO_STATUS_EN
        checkOutput("udr_set", 64'(tx_underrun0), 64'h1);
        repeat (5) @(negedge clk);
        checkOutput("udr_sticky", 64'(tx_underrun0), 64'h1);
        pulseClear();
        checkOutput("udr_clear", 64'(tx_underrun0), 64'h0);
        checkOutput("abort_clear", 64'(frame_abort0), 64'h0);
`endif

        // Partial 5-bit frame, then a full 0x81.
        base0 = strb0;
        applyStimulus(0, 5, 64'h1F, miso);
        checkOutput("part_no_strobe", 64'(strb0 - base0), 64'h0);
        checkOutput("part_rx_hold", 64'(rx_data0), 64'h96);
`ifdef SPI_DEVICE_FIFO_STATUS_EN
        checkOutput("part_abort", 64'(frame_abort0), 64'h1);
`endif
        applyStimulus(0, 8, 64'h81, miso);
        checkOutput("after_part_strobes", 64'(strb0 - base0), 64'h1);
        checkOutput("after_part_rx", 64'(rx_data0), 64'h81);

        // Reset in the middle of a frame with CS low and SCK still running.
        base0 = strb0;
        @(negedge clk);
        cs_n0 = 1'b0;
        #80;
        for (int i = 0; i < 12; i++) begin
            sdi0 = i[0];
            #80;
            sck0 = 1'b1;
            if (i == 3) reset = 1'b1;
            #80;
            sck0 = 1'b0;
            if (i == 3) reset = 1'b0;
        end
        #80;
        checkOutput("rst_mid_no_strobe", 64'(strb0 - base0), 64'h0);
        checkOutput("rst_mid_rx_data", 64'(rx_data0), 64'h0);
        cs_n0 = 1'b1;
        #160;
        checkOutput("rst_mid_no_strobe_cs_high", 64'(strb0 - base0), 64'h0);
        checkOutput("rst_mid_level", 64'(tx_level0), 64'h0);
        pushWord(0, 16'h00C3);
        applyStimulus(0, 8, 64'h7E, miso);
        checkOutput("rst_next_miso", miso, 64'hC3);
        checkOutput("rst_next_rx", 64'(rx_data0), 64'h7E);
        checkOutput("rst_next_strobes", 64'(strb0 - base0), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
